raster_scheduler: RTL

// - Shares the single triangle rasterizer between NUM_REQ vertex producers (e.g. per-mesh vertex transform units).
// - Round-robin arbitration at triangle granularity: a granted requester owns the rasterizer input until its 3 vertices are accepted.
// - Sits between the vertex transform stage and the rasterizer's valid/ready vertex port; counts triangles issued.

---
 rtl/raster_pkg.sv | 15 +
 rtl/rr_picker.sv | 30 +++
 rtl/raster_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/raster_pkg.sv
// Shared types for the raster scheduler: vertex payload, triangle size and FSM state.
package raster_pkg;

    localparam int unsigned COMP_W        = 32;
    localparam int unsigned VERTS_PER_TRI = 3;
    localparam int unsigned VCOUNT_W      = 2;

    typedef logic [3:0][COMP_W-1:0] vertex_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } sched_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first set request searching upward from last_idx+1 (mod NUM_REQ).
module rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_valid
);

    int unsigned idx;
    logic        found;

    always_comb begin : pick
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (32'(last_idx) + i) % NUM_REQ;
            if (!found && req[IDX_W'(idx)]) begin
                grant_idx = IDX_W'(idx);
                found     = 1'b1;
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/raster_scheduler.sv
// Round-robin, triangle-granular arbiter in front of the rasterizer vertex port.
// Define RASTER_SCHED_STATS_EN to add per-requester triangle counters (req_tri_count_out).
module raster_scheduler
    import raster_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned CNT_W    = 16,
    localparam int unsigned GRANT_W = $clog2(NUM_REQ)
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    input  vertex_t [NUM_REQ-1:0]         req_vertex_in,
    output logic                          rast_valid_out,
    input  logic                          rast_ready_in,
    output vertex_t                       rast_vertex_out,
    output logic [GRANT_W-1:0]            grant_id_out,
    output logic                          tri_done_out,
    output logic [CNT_W-1:0]              tri_count_out,
`ifdef RASTER_SCHED_STATS_EN
    output logic [NUM_REQ-1:0][CNT_W-1:0] req_tri_count_out,
`endif
    output logic                          idle_out
);

    sched_state_t        state_q, state_d;
    logic [GRANT_W-1:0]  grant_q, grant_d;
    logic [GRANT_W-1:0]  last_q, last_d;
    logic [GRANT_W-1:0]  pick_idx;
    logic [VCOUNT_W-1:0] vcount_q, vcount_d;
    logic                tri_done_q, tri_done_d;
    logic [CNT_W-1:0]    tri_count_q, tri_count_d;
    logic                any_valid;
    logic                handshake;
    logic                tri_last;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req       (req_valid_in),
        .last_idx  (last_q),
        .grant_idx (pick_idx),
        .any_valid (any_valid)
    );

    // Zero-latency pass-through from the owning requester to the rasterizer.
    always_comb begin : vertex_port
        req_ready_out   = '0;
        rast_valid_out  = 1'b0;
        rast_vertex_out = req_vertex_in[grant_q];
        if (state_q == SEND) begin
            rast_valid_out         = req_valid_in[grant_q];
            req_ready_out[grant_q] = rast_ready_in;
        end
    end

    assign handshake = rast_valid_out && rast_ready_in;
    assign tri_last  = handshake && (vcount_q == VCOUNT_W'(VERTS_PER_TRI - 1));

    always_comb begin : fsm_next
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        vcount_d    = vcount_q;
        tri_done_d  = 1'b0;
        tri_count_d = tri_count_q;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_d  = pick_idx;
                    vcount_d = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (tri_last) begin
                    tri_done_d  = 1'b1;
                    tri_count_d = tri_count_q + CNT_W'(1);
                    last_d      = grant_q;
                    vcount_d    = '0;
                    state_d     = IDLE;
                end else if (handshake) begin
                    vcount_d = vcount_q + VCOUNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin : fsm_regs
        if (!rst_n_in) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            last_q      <= GRANT_W'(NUM_REQ - 1);
            vcount_q    <= '0;
            tri_done_q  <= 1'b0;
            tri_count_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            vcount_q    <= vcount_d;
            tri_done_q  <= tri_done_d;
            tri_count_q <= tri_count_d;
        end
    end

    assign grant_id_out  = grant_q;
    assign tri_done_out  = tri_done_q;
    assign tri_count_out = tri_count_q;
    assign idle_out      = (state_q == IDLE) && !(|req_valid_in);

`ifdef RASTER_SCHED_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] req_cnt_q;

    always_ff @(posedge clk_in) begin : stats_regs
        if (!rst_n_in) begin
            req_cnt_q <= '0;
        end else if (tri_last) begin
            req_cnt_q[grant_q] <= req_cnt_q[grant_q] + CNT_W'(1);
        end
    end

    assign req_tri_count_out = req_cnt_q;
`endif

endmodule
